// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit
// Description : Iterative shift-add RV32M multiplier (mul/mulh/mulhsu/mulhu),
//               one bit per cycle, start/done handshake, flush abort.
//               Optional early termination: define MUL_EARLY_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      mulctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            mul_done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_sel_hi;
    logic                r_neg_res;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_result;

    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [2*XLEN-1:0]   w_acc_sum;
    logic [2*XLEN-1:0]   w_product;
    logic                w_last;
    logic [XLEN-1:0]     w_sel;
    logic                w_done_ok;

    assign w_sign_a  = op_a[XLEN-1] & ((mulctl == 2'b01) | (mulctl == 2'b10));
    assign w_sign_b  = op_b[XLEN-1] & (mulctl == 2'b01);
    assign w_mag_a   = w_sign_a ? (~op_a + 1'b1) : op_a;
    assign w_mag_b   = w_sign_b ? (~op_b + 1'b1) : op_b;
    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_product = r_neg_res ? (~w_acc_sum + 1'b1) : w_acc_sum;

`ifdef MUL_EARLY_OUT_EN
    // No set bits left above the current one: this add is the final one.
    assign w_last = (r_cnt == CNT_W'(XLEN-1)) || (r_mplier[XLEN-1:1] == '0);
`else
    assign w_last = (r_cnt == CNT_W'(XLEN-1));
`endif

    assign w_sel     = r_sel_hi ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    assign w_done_ok = (r_state == DONE) && !flush;

    // The sign-corrected product is already in r_acc during DONE, so the
    // selected half is visible in the done cycle and latched for holding.
    assign busy     = (r_state == RUN);
    assign mul_done = w_done_ok;
    assign result   = w_done_ok ? w_sel : r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel_hi  <= 1'b0;
            r_neg_res <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !flush) begin
                        r_sel_hi  <= (mulctl != 2'b00);
                        r_neg_res <= w_sign_a ^ w_sign_b;
                        r_acc     <= '0;
                        r_mcand   <= {{XLEN{1'b0}}, w_mag_a};
                        r_mplier  <= w_mag_b;
                        r_cnt     <= '0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc    <= w_last ? w_product : w_acc_sum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!flush) begin
                        r_result <= w_sel;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// Directed self-checking bench for mul_unit (XLEN=32).
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mulctl = 2'b00;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        mul_done;
    logic [31:0] result;

    int compared = 0;
    int mismatched = 0;

    mul_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mulctl(mulctl),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy), .mul_done(mul_done), .result(result)
    );

    always #5 clk = ~clk;

`ifdef MUL_EARLY_OUT_EN
    localparam int LAT_B2    = 3;
    localparam int LAT_B7    = 4;
    localparam int BUSY_B2   = 2;
`else
    localparam int LAT_B2    = 33;
    localparam int LAT_B7    = 33;
    localparam int BUSY_B2   = 32;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge of cycle 1 (first RUN cycle).
    task automatic launch(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mulctl = ctl; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples from cycle c0 on; returns the cycle of mul_done (-1 on timeout).
    task automatic wait_done(input int c0, output int lat, output int busy_n, output logic [31:0] res);
        lat = -1; busy_n = 0; res = 'x;
        for (int c = c0; c <= 45; c++) begin
            if (mul_done) begin
                lat = c; res = result;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_n, output logic [31:0] res);
        launch(ctl, a, b);
        wait_done(1, lat, busy_n, res);
    endtask

    initial begin
        int          lat, bn, n_done, pulses_wide;
        int          done_at [3];
        logic [31:0] res;
        logic        prev_done;

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, mul_done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // mul low half, latency and busy window
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, lat, bn, res);
        check("mul_ff_x2", res, 32'hFFFF_FFFE);
        check("mul_ff_x2_lat", lat, LAT_B2);
        check("mul_ff_x2_busy", bn, BUSY_B2);
        check("done_busy_low", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, mul_done}, 32'd0);
        check("result_hold", result, 32'hFFFF_FFFE);

        // High-half variants on -1 / 2^32-1
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn, res);
        check("mulh_ff_ff", res, 32'h0000_0000);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn, res);
        check("mulhu_ff_ff", res, 32'hFFFF_FFFE);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn, res);
        check("mulhsu_ff_ff", res, 32'hFFFF_FFFF);

        // Most-negative corner
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, bn, res);
        check("mulh_min_min", res, 32'h4000_0000);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, bn, res);
        check("mul_min_min", res, 32'h0000_0000);
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, lat, bn, res);
        check("mulh_neg2_x3", res, 32'hFFFF_FFFF);

        // Operand change mid-run is ignored: 3 * 0x80000005 low half
        launch(2'b00, 32'd3, 32'h8000_0005);
        repeat (4) @(negedge clk);
        op_a = 32'd100; op_b = 32'd0;
        wait_done(5, lat, bn, res);
        check("opa_change", res, 32'h8000_000F);

        // start during RUN is ignored
        launch(2'b11, 32'd9, 32'h8000_0000);
        repeat (3) @(negedge clk);
        start = 1'b1; mulctl = 2'b00; op_a = 32'd1; op_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, lat, bn, res);
        check("start_busy_ign", res, 32'h0000_0004);
        check("start_busy_lat", lat, 33);

        // flush at cycle 20: no pulse, result retained
        launch(2'b11, 32'h1234_5678, 32'h8000_0000);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        wait_done(21, lat, bn, res);
        check("flush_no_done", lat, -1);
        check("flush_result", result, 32'h0000_0004);

        // start with flush in IDLE launches nothing
        @(negedge clk);
        start = 1'b1; flush = 1'b1; mulctl = 2'b00; op_a = 32'd2; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", {31'd0, busy}, 32'd0);

        // Async reset mid-run
        launch(2'b00, 32'd3, 32'h8000_0005);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_done", {31'd0, mul_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 32'd6, 32'd7, lat, bn, res);
        check("arst_restart", res, 32'd42);
        check("arst_restart_lat", lat, LAT_B7);

        // start held high: launches at 0, 34, 68 -> done at 33, 67, 101
        @(negedge clk);
        mulctl = 2'b00; op_a = 32'd3; op_b = 32'h8000_0000; start = 1'b1;
        n_done = 0; pulses_wide = 0; prev_done = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (mul_done && prev_done) pulses_wide++;
            if (mul_done && n_done < 3) begin
                done_at[n_done] = c;
                n_done++;
            end
            prev_done = mul_done;
        end
        start = 1'b0;
        check("b2b_count", n_done, 3);
        check("b2b_first", (n_done > 0) ? done_at[0] : -1, 33);
        check("b2b_second", (n_done > 1) ? done_at[1] : -1, 67);
        check("b2b_third", (n_done > 2) ? done_at[2] : -1, 101);
        check("b2b_width", pulses_wide, 0);
        check("b2b_result", result, 32'h8000_0000);
        repeat (40) @(negedge clk);

`ifdef MUL_EARLY_OUT_EN
        run_op(2'b00, 32'd7, 32'd1, lat, bn, res);
        check("eo_b1_res", res, 32'd7);
        check("eo_b1_lat", lat, 2);
        run_op(2'b00, 32'd7, 32'd0, lat, bn, res);
        check("eo_b0_res", res, 32'd0);
        check("eo_b0_lat", lat, 2);
        run_op(2'b11, 32'd7, 32'h8000_0000, lat, bn, res);
        check("eo_msb_res", res, 32'd3);
        check("eo_msb_lat", lat, 33);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative shift-add integer multiplier for the RV32M multiply group: mul, mulh, mulhsu, mulhu.
- Sits in the EX stage beside the ALU and is driven by the EX controller's 2-bit mulctl.
- Returns a mul_done pulse to the EX controller; the EX result mux selects its result.
- Multi-cycle, one operation in flight, start/done handshake.

Parameters:
- XLEN, 32, operand and result width; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- mulctl  input  2  operation, sampled with start: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu.
- op_a  input  XLEN  rs1 value, sampled with start.
- op_b  input  XLEN  rs2 value, sampled with start.
- flush  input  1  synchronous abort of the in-flight operation (pipeline kill).
- busy  output  1  high while an operation is in progress.
- mul_done  output  1  one-cycle pulse when result is valid.
- result  output  XLEN  selected half of the 2*XLEN product.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, mul_done=0, result=0.
  - Internal accumulator, multiplicand, multiplier and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches mulctl, sign flags and operand magnitudes, then goes to RUN; busy=1 from the next cycle.
  - Sign rules:
    - a is signed for 01 and 10; b is signed for 01 only.
    - A signed operand with MSB=1 is two's-complement negated to its magnitude.
    - neg_res = sign_a XOR sign_b, using the effective sign flags only.
  - Accumulator width is 2*XLEN, unsigned.
- RUN: one multiplier bit per cycle, for XLEN cycles (counter 0..XLEN-1).
  - If multiplier LSB=1, add the multiplicand (zero-extended to 2*XLEN, pre-shifted) to the accumulator.
  - Then shift the multiplicand left 1 and the multiplier right 1.
  - After the last iteration, go to DONE.
- DONE, lasting one cycle:
  - Take p = neg_res ? -acc : acc, modulo 2^(2*XLEN).
  - Set result = p[XLEN-1:0] for mulctl 00, else p[2*XLEN-1:XLEN].
  - mul_done=1 and busy=0 this cycle; next state IDLE.
- Output hold: result holds its value until the next DONE. Only reset clears it; flush does not.
- Latency (feature off): start asserted in cycle 0 -> mul_done high in cycle XLEN+1, i.e. cycle 33 for XLEN=32. Fixed, independent of operands.
- Back-to-back: start in the same cycle as mul_done is ignored, because the state is DONE, not IDLE. Earliest restart is the cycle after mul_done.
- start while busy is ignored; latched operands are unaffected.
- flush:
  - In RUN or DONE: next state IDLE, busy=0; mul_done is suppressed that cycle if in DONE; result keeps its prior value.
  - In IDLE together with start: flush wins and no operation is launched.
- Special cases, no exception states; all arithmetic is modulo 2^(2*XLEN):
  - mulh of -2^31 x -2^31 gives 0x40000000.
  - Overflow corner cases fall out naturally from the modulo arithmetic.
- Async reset mid-RUN returns to IDLE immediately; no pulse is generated.

Optional Feature:
- Macro: MUL_EARLY_OUT_EN.
- Defined:
  - In RUN, when the remaining (shifted) multiplier is zero, the current iteration is the last and the next state is DONE.
  - The check also applies before the first iteration: a zero multiplier magnitude goes IDLE -> RUN (1 cycle) -> DONE.
  - Latency becomes 2 + index of the highest set bit of |b|, with minimum 2 and maximum XLEN+1.
  - Results are bit-identical to the feature-off case.
- Undefined: fixed XLEN-iteration latency as above; no zero-detect logic is synthesised.

Test Plan:
- Reset mid-RUN: start mul, 3*5; drop rst_n at cycle 10 -> busy=0, result=0, no mul_done; a fresh start then completes normally.
- mul, signed/unsigned low: a=0xFFFFFFFF, b=2 -> result 0xFFFFFFFE; mul_done exactly at cycle 33; busy high cycles 1-32.
- mulh / mulhu / mulhsu with a=0xFFFFFFFF, b=0xFFFFFFFF:
  - mulh -> 0x00000000.
  - mulhu -> 0xFFFFFFFE.
  - mulhsu -> 0xFFFFFFFF.
- mulh corner: a=b=0x80000000 -> 0x40000000; mul of the same operands -> 0x00000000.
- Handshake:
  - start held high continuously -> operations at cycles 0, 34, 68; mul_done pulses are exactly one cycle wide.
  - Changing op_a mid-RUN has no effect on the result.
- flush at cycle 20 of a RUN -> busy=0 next cycle, no mul_done, result retains the previous value.
- With MUL_EARLY_OUT_EN: a=7, b=1 -> mul_done at cycle 2, result 7; b=0 -> mul_done at cycle 2, result 0; b=0x80000000 (mulhu) -> cycle 33.
